// File: rtl/input_mapper.sv
// Purpose: merges PS/2 key events and joystick words into per-player direction, button, start, coin and pause signals.
// Latency: joystick -> outputs 1 cycle; PS/2 event -> key register 1 cycle, -> outputs 2 cycles.
// Backpressure: none; inputs are sampled every cycle and every output is a level that is always valid.
module input_mapper #(
  parameter int PLAYERS         = 2,
  parameter int BUTTONS         = 4,
  parameter int AUTOFIRE_PERIOD = 4096,
  parameter int COIN_PULSE      = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [10:0]                ps2_key,
  input  logic [PLAYERS*32-1:0]      joystick,
  input  logic [BUTTONS-1:0]         autofire_mask,
  input  logic [1:0]                 socd_mode,
  output logic [PLAYERS*4-1:0]       dir,
  output logic [PLAYERS*BUTTONS-1:0] buttons,
  output logic [PLAYERS-1:0]         start,
  output logic [PLAYERS-1:0]         coin,
  output logic [PLAYERS-1:0]         pause
);

  localparam int AF_W   = ($clog2(AUTOFIRE_PERIOD) < 1) ? 1 : $clog2(AUTOFIRE_PERIOD);
  localparam int COIN_W = ($clog2(COIN_PULSE) < 1) ? 1 : $clog2(COIN_PULSE);
  localparam logic [AF_W-1:0]   AF_LAST   = AF_W'(AUTOFIRE_PERIOD - 1);
  localparam logic [COIN_W-1:0] COIN_LOAD = COIN_W'(COIN_PULSE - 1);

  // Only two players have keyboard maps, and only the first four buttons of each.
  localparam int         KEY_BTNS    = (BUTTONS < 4) ? BUTTONS : 4;
  localparam logic [3:0] KEY_BTN_END = 4'(4 + KEY_BTNS);
  localparam logic       KEY_P1_EN   = (PLAYERS >= 2);

  // Key register slot layout: 0 right, 1 left, 2 down, 3 up, 4..7 buttons, 8 start, 9 coin, 10 pause.
  localparam logic [3:0] SLOT_START = 4'd8;
  localparam logic [3:0] SLOT_COIN  = 4'd9;
  localparam logic [3:0] SLOT_PAUSE = 4'd10;

  logic                   tog_q;
  logic                   ps2_ev;
  logic                   dec_hit;
  logic                   dec_p;
  logic [3:0]             dec_s;
  logic                   key_wr;
  logic [1:0][10:0]       key_q;
  logic [PLAYERS-1:0][10:0] key_ext;
  logic [AF_W-1:0]        af_cnt;
  logic                   phase;
  logic                   unused_bits;

  // The extended flag, unmapped slots and unused joystick bits are deliberately ignored.
  assign unused_bits = ^{joystick, key_q, key_ext, ps2_key[8]};

  assign ps2_ev = ps2_key[10] ^ tog_q;

  // Scan-code decode to {player, slot}; unknown codes produce no hit.
  always_comb begin
    dec_hit = 1'b1;
    dec_p   = 1'b0;
    dec_s   = 4'd0;
    case (ps2_key[7:0])
      8'h74: dec_s = 4'd0;
      8'h6B: dec_s = 4'd1;
      8'h72: dec_s = 4'd2;
      8'h75: dec_s = 4'd3;
      8'h14: dec_s = 4'd4;
      8'h11: dec_s = 4'd5;
      8'h29: dec_s = 4'd6;
      8'h12: dec_s = 4'd7;
      8'h16: dec_s = SLOT_START;
      8'h2E: dec_s = SLOT_COIN;
      8'h4D: dec_s = SLOT_PAUSE;
      8'h34: begin dec_p = 1'b1; dec_s = 4'd0; end
      8'h23: begin dec_p = 1'b1; dec_s = 4'd1; end
      8'h2B: begin dec_p = 1'b1; dec_s = 4'd2; end
      8'h2D: begin dec_p = 1'b1; dec_s = 4'd3; end
      8'h1C: begin dec_p = 1'b1; dec_s = 4'd4; end
      8'h1B: begin dec_p = 1'b1; dec_s = 4'd5; end
      8'h15: begin dec_p = 1'b1; dec_s = 4'd6; end
      8'h1D: begin dec_p = 1'b1; dec_s = 4'd7; end
      8'h1E: begin dec_p = 1'b1; dec_s = SLOT_START; end
      8'h36: begin dec_p = 1'b1; dec_s = SLOT_COIN; end
      default: dec_hit = 1'b0;
    endcase
  end

  // Keys for players or buttons this instance does not have are dropped.
  assign key_wr = ps2_ev & dec_hit & (~dec_p | KEY_P1_EN) &
                  ((dec_s < 4'd4) | (dec_s > 4'd7) | (dec_s < KEY_BTN_END));

  // Toggle copy and key state; the copy tracks the input during reset so release is event-free.
  always_ff @(posedge clk) begin
    tog_q <= ps2_key[10];
    if (rst) begin
      key_q <= '0;
    end else if (key_wr) begin
      key_q[dec_p][dec_s] <= ps2_key[9];
    end
  end

  // Free-running autofire timebase; phase flips each time the counter wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      af_cnt <= '0;
      phase  <= 1'b0;
    end else if (af_cnt == AF_LAST) begin
      af_cnt <= '0;
      phase  <= ~phase;
    end else begin
      af_cnt <= af_cnt + AF_W'(1);
    end
  end

  for (genvar p = 0; p < PLAYERS; p++) begin : g_key_ext
    if (p < 2) begin : g_kb
      assign key_ext[p] = key_q[p];
    end else begin : g_nokb
      assign key_ext[p] = '0;
    end
  end

  for (genvar p = 0; p < PLAYERS; p++) begin : g_player
    localparam int J = p * 32;

    logic [3:0]         raw_dir;
    logic [3:0]         raw_dir_q;
    logic [3:0]         rise_dir;
    logic [3:0]         clean_dir;
    logic [3:0]         dir_q;
    logic [BUTTONS-1:0] raw_btn;
    logic [BUTTONS-1:0] raw_btn_q;
    logic [BUTTONS-1:0] btn_nxt;
    logic [BUTTONS-1:0] btn_q;
    logic               raw_start;
    logic               raw_coin;
    logic               raw_pause;
    logic               raw_coin_q;
    logic               coin_rise;
    logic               start_q;
    logic               coin_q;
    logic               pause_q;
    logic               last_ud;
    logic               last_lr;
    logic               last_ud_n;
    logic               last_lr_n;
    logic [COIN_W-1:0]  coin_cnt;

    assign raw_dir = key_ext[p][3:0] | joystick[J +: 4];

    for (genvar b = 0; b < BUTTONS; b++) begin : g_btn
      if (b < 4) begin : g_key
        assign raw_btn[b] = key_ext[p][4+b] | joystick[J+4+b];
      end else begin : g_joy
        assign raw_btn[b] = joystick[J+4+b];
      end
    end

    assign raw_start = key_ext[p][8]  | joystick[J+4+BUTTONS];
    assign raw_coin  = key_ext[p][9]  | joystick[J+5+BUTTONS];
    assign raw_pause = key_ext[p][10] | joystick[J+6+BUTTONS];
    assign coin_rise = raw_coin & ~raw_coin_q;

    // An autofire button fires on its press edge, then follows the phase square wave.
    assign btn_nxt = raw_btn & ({BUTTONS{phase}} | ~autofire_mask | (raw_btn & ~raw_btn_q));

    // SOCD per axis; "last" = 0 means up/left rose most recently, a simultaneous rise keeps it.
    always_comb begin
      rise_dir  = raw_dir & ~raw_dir_q;
      last_ud_n = last_ud;
      last_lr_n = last_lr;
      clean_dir = raw_dir;
      if (rise_dir[3] && !rise_dir[2]) last_ud_n = 1'b0;
      else if (rise_dir[2] && !rise_dir[3]) last_ud_n = 1'b1;
      if (rise_dir[1] && !rise_dir[0]) last_lr_n = 1'b0;
      else if (rise_dir[0] && !rise_dir[1]) last_lr_n = 1'b1;
      if (raw_dir[3] && raw_dir[2]) begin
        if (socd_mode == 2'd1) clean_dir[3:2] = 2'b00;
        else if (socd_mode == 2'd2) clean_dir[3:2] = {~last_ud_n, last_ud_n};
      end
      if (raw_dir[1] && raw_dir[0]) begin
        if (socd_mode == 2'd1) clean_dir[1:0] = 2'b00;
        else if (socd_mode == 2'd2) clean_dir[1:0] = {~last_lr_n, last_lr_n};
      end
    end

    // Edge history, coin stretch counter and the single output register stage.
    always_ff @(posedge clk) begin
      if (rst) begin
        raw_dir_q  <= '0;
        raw_btn_q  <= '0;
        raw_coin_q <= 1'b0;
        last_ud    <= 1'b0;
        last_lr    <= 1'b0;
        coin_cnt   <= '0;
        dir_q      <= '0;
        btn_q      <= '0;
        start_q    <= 1'b0;
        coin_q     <= 1'b0;
        pause_q    <= 1'b0;
      end else begin
        raw_dir_q  <= raw_dir;
        raw_btn_q  <= raw_btn;
        raw_coin_q <= raw_coin;
        last_ud    <= last_ud_n;
        last_lr    <= last_lr_n;
        if (coin_rise) coin_cnt <= COIN_LOAD;
        else if (coin_cnt != '0) coin_cnt <= coin_cnt - COIN_W'(1);
        dir_q      <= clean_dir;
        btn_q      <= btn_nxt;
        start_q    <= raw_start;
        coin_q     <= raw_coin | (coin_cnt != '0) | coin_rise;
        pause_q    <= raw_pause;
      end
    end

    assign dir[p*4 +: 4]             = dir_q;
    assign buttons[p*BUTTONS +: BUTTONS] = btn_q;
    assign start[p]                  = start_q;
    assign coin[p]                   = coin_q;
    assign pause[p]                  = pause_q;
  end

endmodule

// File: tb/tb_input_mapper.sv
// Purpose: directed stimulus for input_mapper with a queued scoreboard checked by an independent monitor.
// Latency: expectations are stamped with the clock edge whose registered outputs they describe.
// Backpressure: none; the monitor checks every queued expectation on its stamped cycle.
module tb_input_mapper;

  localparam int PLAYERS    = 3;
  localparam int BUTTONS    = 6;
  localparam int AF_PERIOD  = 4;
  localparam int COIN_PULSE = 8;
  localparam int SEL_DIR    = 0;
  localparam int SEL_BTN    = 1;
  localparam int SEL_START  = 2;
  localparam int SEL_COIN   = 3;
  localparam int SEL_PAUSE  = 4;
  localparam int J_COIN0    = 4 + BUTTONS + 1;

  logic                       clk_sys = 1'b0;
  logic                       RESET;
  logic [10:0]                ps2_key;
  logic [PLAYERS*32-1:0]      joystick;
  logic [BUTTONS-1:0]         autofire_mask;
  logic [1:0]                 socd_mode;
  logic [PLAYERS*4-1:0]       dir;
  logic [PLAYERS*BUTTONS-1:0] buttons;
  logic [PLAYERS-1:0]         start;
  logic [PLAYERS-1:0]         coin;
  logic [PLAYERS-1:0]         pause;

  typedef struct {
    int          cyc;
    string       nm;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc     = 0;
  int   n_vec   = 0;
  int   n_bad   = 0;
  int   rst_cyc = 0;
  logic tog     = 1'b0;

  input_mapper #(
    .PLAYERS(PLAYERS),
    .BUTTONS(BUTTONS),
    .AUTOFIRE_PERIOD(AF_PERIOD),
    .COIN_PULSE(COIN_PULSE)
  ) dut (
    .clk(clk_sys),
    .rst(RESET),
    .ps2_key(ps2_key),
    .joystick(joystick),
    .autofire_mask(autofire_mask),
    .socd_mode(socd_mode),
    .dir(dir),
    .buttons(buttons),
    .start(start),
    .coin(coin),
    .pause(pause)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic step(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  function automatic void expect1(input int c, input string nm, input int sel, input logic [31:0] v);
    exp_t e;
    e.cyc = c;
    e.nm  = nm;
    e.sel = sel;
    e.val = v;
    sb.push_back(e);
  endfunction

  function automatic void expect_quiet(input int c, input string nm);
    expect1(c, {nm, "_dir"},   SEL_DIR,   32'h0);
    expect1(c, {nm, "_btn"},   SEL_BTN,   32'h0);
    expect1(c, {nm, "_start"}, SEL_START, 32'h0);
    expect1(c, {nm, "_coin"},  SEL_COIN,  32'h0);
    expect1(c, {nm, "_pause"}, SEL_PAUSE, 32'h0);
  endfunction

  task automatic ps2_event(input logic pressed, input logic [7:0] code);
    tog     = ~tog;
    ps2_key = {tog, pressed, 1'b0, code};
  endtask

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      SEL_DIR:   return 32'(dir);
      SEL_BTN:   return 32'(buttons);
      SEL_START: return 32'(start);
      SEL_COIN:  return 32'(coin);
      default:   return 32'(pause);
    endcase
  endfunction

  // Monitor: after every rising edge, check and retire expectations stamped with that edge.
  initial begin : monitor
    forever begin
      @(posedge clk_sys);
      #1;
      cyc++;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc <= cyc) begin
          n_vec++;
          if (sb[i].cyc < cyc) begin
            n_bad++;
            $display("FAIL %s: expectation for cycle %0d was missed (now %0d)", sb[i].nm, sb[i].cyc, cyc);
          end else if (actual(sb[i].sel) !== sb[i].val) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h, expected %0h", sb[i].nm, cyc, actual(sb[i].sel), sb[i].val);
          end
          sb.delete(i);
        end
      end
    end
  end

  initial begin : stim
    int c;
    RESET = 1'b1;
    ps2_key = '0;
    joystick = '0;
    autofire_mask = '0;
    socd_mode = 2'd0;
    step(2);
    expect_quiet(cyc + 1, "reset");
    step(1);
    rst_cyc = cyc;
    RESET = 1'b0;

    // Key decode, latency, no-event and back-to-back events.
    step(1);
    ps2_event(1'b1, 8'h14); c = cyc;
    expect1(c + 1, "key_latency", SEL_BTN, 32'h0);
    expect1(c + 2, "key_press", SEL_BTN, 32'h1);
    expect1(c + 2, "key_press_dir", SEL_DIR, 32'h0);
    step(3);
    ps2_event(1'b0, 8'h14); c = cyc;
    expect1(c + 1, "key_held", SEL_BTN, 32'h1);
    expect1(c + 2, "key_release", SEL_BTN, 32'h0);
    step(3);
    ps2_key[9] = 1'b1; c = cyc;
    expect1(c + 2, "key_no_event", SEL_BTN, 32'h0);
    expect1(c + 3, "key_no_event2", SEL_BTN, 32'h0);
    step(3);
    ps2_event(1'b1, 8'h16); c = cyc;
    expect1(c + 2, "key_start", SEL_START, 32'h1);
    expect1(c + 2, "key_start_btn", SEL_BTN, 32'h0);
    step(1);
    ps2_event(1'b0, 8'h16);
    expect1(c + 3, "key_start_b2b", SEL_START, 32'h0);
    step(3);
    tog = ~tog;
    ps2_key = {tog, 1'b1, 1'b1, 8'h11}; c = cyc;
    expect1(c + 2, "key_ext_flag", SEL_BTN, 32'h2);
    step(1);
    ps2_event(1'b1, 8'h1C);
    expect1(c + 3, "key_p1_b0", SEL_BTN, 32'h42);
    step(1);
    ps2_event(1'b0, 8'h11);
    step(1);
    ps2_event(1'b0, 8'h1C); c = cyc;
    expect1(c + 2, "key_all_released", SEL_BTN, 32'h0);
    step(3);
    ps2_event(1'b1, 8'h5A); c = cyc;
    expect1(c + 2, "key_unmapped_btn", SEL_BTN, 32'h0);
    expect1(c + 2, "key_unmapped_start", SEL_START, 32'h0);
    step(1);
    ps2_event(1'b0, 8'h5A);
    step(3);

    // Joystick merge across the full width.
    joystick[2*32 + 9] = 1'b1; c = cyc;
    expect1(c + 1, "joy_p2_btn5", SEL_BTN, 32'h20000);
    step(1);
    joystick = '0;
    joystick[2*32 + 10] = 1'b1; c = cyc;
    expect1(c + 1, "joy_p2_start", SEL_START, 32'h4);
    expect1(c + 1, "joy_p2_btn5_off", SEL_BTN, 32'h0);
    step(1);
    joystick = '0;
    joystick[1*32 + 12] = 1'b1; c = cyc;
    expect1(c + 1, "joy_p1_pause", SEL_PAUSE, 32'h2);
    step(1);
    joystick = '0;
    step(2);

    // SOCD cleaning.
    socd_mode = 2'd1;
    joystick[3] = 1'b1;
    joystick[2] = 1'b1;
    expect1(cyc + 1, "socd_neutral", SEL_DIR, 32'h0);
    step(2);
    expect1(cyc + 1, "socd_neutral_hold", SEL_DIR, 32'h0);
    step(1);
    socd_mode = 2'd0;
    expect1(cyc + 1, "socd_pass", SEL_DIR, 32'hC);
    step(1);
    joystick = '0;
    step(2);
    socd_mode = 2'd2;
    joystick[3] = 1'b1;
    expect1(cyc + 1, "socd_up", SEL_DIR, 32'h8);
    step(5);
    joystick[2] = 1'b1;
    expect1(cyc + 1, "socd_down_wins", SEL_DIR, 32'h4);
    step(3);
    expect1(cyc + 1, "socd_down_hold", SEL_DIR, 32'h4);
    step(1);
    joystick[2] = 1'b0;
    expect1(cyc + 1, "socd_down_rel", SEL_DIR, 32'h8);
    step(1);
    joystick = '0;
    step(2);
    joystick[1] = 1'b1;
    joystick[0] = 1'b1;
    expect1(cyc + 1, "socd_lr_tie", SEL_DIR, 32'h2);
    step(1);
    joystick = '0;
    socd_mode = 2'd0;
    step(2);

    // Autofire: start while phase is low so the first shot comes from the press edge.
    autofire_mask = 6'b000001;
    while (((cyc - rst_cyc) / AF_PERIOD) % 2 != 0) step(1);
    joystick[4] = 1'b1; c = cyc;
    for (int i = 1; i <= 32; i++) begin
      int k;
      k = c + i;
      expect1(k, "autofire", SEL_BTN, (i == 1) ? 32'h1 : 32'(((k - 1 - rst_cyc) / AF_PERIOD) % 2));
    end
    step(32);
    joystick[4] = 1'b0;
    expect1(cyc + 1, "autofire_release", SEL_BTN, 32'h0);
    step(1);
    autofire_mask = '0;
    step(2);

    // Coin stretching: single pulse, long hold, re-press while running.
    c = cyc;
    for (int i = 1; i <= COIN_PULSE + 1; i++) expect1(c + i, "coin_pulse", SEL_COIN, (i <= COIN_PULSE) ? 32'h1 : 32'h0);
    joystick[J_COIN0] = 1'b1;
    step(1);
    joystick[J_COIN0] = 1'b0;
    step(12);
    c = cyc;
    for (int i = 1; i <= 21; i++) expect1(c + i, "coin_hold", SEL_COIN, (i <= 20) ? 32'h1 : 32'h0);
    joystick[J_COIN0] = 1'b1;
    step(20);
    joystick[J_COIN0] = 1'b0;
    step(12);
    c = cyc;
    for (int i = 1; i <= 14; i++) expect1(c + i, "coin_repress", SEL_COIN, (i <= 13) ? 32'h1 : 32'h0);
    joystick[J_COIN0] = 1'b1;
    step(1);
    joystick[J_COIN0] = 1'b0;
    step(4);
    joystick[J_COIN0] = 1'b1;
    step(1);
    joystick[J_COIN0] = 1'b0;
    step(12);

    // Reset in the middle of a coin pulse and a held autofire button.
    autofire_mask = 6'b000001;
    joystick[4] = 1'b1;
    joystick[J_COIN0] = 1'b1; c = cyc;
    expect1(c + 3, "rst_pre_coin", SEL_COIN, 32'h1);
    step(1);
    joystick[J_COIN0] = 1'b0;
    step(2);
    RESET = 1'b1;
    tog = 1'b1;
    ps2_key = {1'b1, 1'b1, 1'b0, 8'h14};
    expect_quiet(cyc + 1, "rst_mid");
    step(1);
    joystick = '0;
    autofire_mask = '0;
    step(1);
    rst_cyc = cyc;
    RESET = 1'b0; c = cyc;
    for (int i = 1; i <= 4; i++) expect_quiet(c + i, "rst_release");
    step(6);

    for (int i = 0; i < 50 && sb.size() != 0; i++) step(1);
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d expectations still pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
